// File: rtl/half_duplex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : half_duplex_pkg
// Function : Shared types and helpers for the half-duplex responder.
// Revision : 1.0 - initial release
// ============================================================================
package half_duplex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        TURN  = 2'd2,
        DRIVE = 2'd3
    } state_t;

    // Address width for a register bank of the given depth (minimum 1 bit).
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : half_duplex_pkg
`default_nettype wire

// File: rtl/half_duplex_regfile.sv
`default_nettype none
// ============================================================================
// Module   : half_duplex_regfile
// Function : DEPTH x WIDTH register bank, one sync write port, one async read
//            port, asynchronously cleared on rst.
// Revision : 1.0 - initial release
// ============================================================================
module half_duplex_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : half_duplex_regfile
`default_nettype wire

// File: rtl/half_duplex_responder.sv
`default_nettype none
// ============================================================================
// Module   : half_duplex_responder
// Function : Responder end of a shared half-duplex bus; accepts write/read
//            commands into a register bank and turns the bus around to return
//            read data for one cycle.
// Options  : RESP_TIMEOUT_EN - abandon a write stuck in WDATA after TIMEOUT
//            idle cycles and flag err.
// Revision : 1.0 - initial release
// ============================================================================
module half_duplex_responder
    import half_duplex_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             cmd_valid,
    input  logic             cmd_rw,
    output logic             rsp_oe,
    output logic             rsp_valid,
    output logic             busy,
    output logic             err
);

    localparam int AW = addr_bits(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AW > WIDTH) || (TIMEOUT < 1))
        begin : g_param_check
            $error("half_duplex_responder: illegal DEPTH/WIDTH/TIMEOUT combination");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_addr_q;
    logic [WIDTH-1:0] r_data_q;
    logic             r_rsp_oe;
    logic             r_err;
    logic             w_addr_load;
    logic             w_we;
    logic             w_err_set;
    logic             w_to_hit;
    logic [WIDTH-1:0] w_rdata;

`ifdef RESP_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CW-1:0] r_to_cnt;

    // Fires on the TIMEOUT-th consecutive idle WDATA cycle.
    assign w_to_hit = (r_state == WDATA) && !cmd_valid && (r_to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == WDATA) && !cmd_valid && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_addr_load = 1'b0;
        w_we        = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_addr_load = 1'b1;
                    w_state_nxt = cmd_rw ? TURN : WDATA;
                end
            end
            WDATA: begin
                if (cmd_valid) begin
                    w_we        = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_to_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            TURN: begin
                w_err_set   = cmd_valid;
                w_state_nxt = DRIVE;
            end
            DRIVE: begin
                w_err_set   = cmd_valid;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr_q <= '0;
            r_data_q <= '0;
            r_rsp_oe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_addr_load) begin
                r_addr_q <= bus[AW-1:0];
            end
            if (r_state == TURN) begin
                r_data_q <= w_rdata;
            end
            // Output enable is a flop so the bus never follows inputs combinationally.
            r_rsp_oe <= (w_state_nxt == DRIVE);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    half_duplex_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_addr_q),
        .i_wdata (bus),
        .i_raddr (r_addr_q),
        .o_rdata (w_rdata)
    );

    assign bus       = r_rsp_oe ? r_data_q : {WIDTH{1'bz}};
    assign rsp_oe    = r_rsp_oe;
    assign rsp_valid = r_rsp_oe;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule : half_duplex_responder
`default_nettype wire
